// File: rtl/cam_pkg.sv
// Shared constants and the per-entry match predicate for the CAM search pipeline.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cam_pkg;

  localparam int CAM_DEPTH_DEF = 8;
  localparam int CAM_WIDTH_DEF = 8;
  localparam int CAM_MAX_W     = 64;

  // An entry matches when it is valid and every bit cared about by both the
  // stored mask and the search mask agrees. Operands are zero-extended to the
  // maximum width, so unused upper bits always compare equal.
  function automatic logic cam_entry_match(
    input logic                 vld,
    input logic [CAM_MAX_W-1:0] data,
    input logic [CAM_MAX_W-1:0] entry_mask,
    input logic [CAM_MAX_W-1:0] word,
    input logic [CAM_MAX_W-1:0] search_mask
  );
    logic [CAM_MAX_W-1:0] care;
    care = ~(entry_mask | search_mask);
    return vld && (((data ^ word) & care) == '0);
  endfunction

endpackage

// File: rtl/cam_priority_enc.sv
// Priority encoder for a match vector: lowest set index, any-hit and multi-hit flags.
// Latency: purely combinational.
// Backpressure: none; follows its input.
//
// Ports:
//   vec_i   : decoded match vector
//   found_o : at least one bit set
//   addr_o  : lowest set index, 0 when vec_i is empty
//   multi_o : two or more bits set
module cam_priority_enc #(
  parameter int CAM_DEPTH = 8,
  parameter int ADDR_W    = $clog2(CAM_DEPTH)
) (
  input  logic [CAM_DEPTH-1:0] vec_i,
  output logic                 found_o,
  output logic [ADDR_W-1:0]    addr_o,
  output logic                 multi_o
);

  logic [CAM_DEPTH-1:0] low_cleared;

  // Scan from the top down so the last assignment wins for the lowest index.
  always_comb begin
    addr_o = '0;
    for (int i = CAM_DEPTH - 1; i >= 0; i--) begin
      if (vec_i[i]) addr_o = ADDR_W'(i);
    end
  end

  // Clearing the lowest set bit leaves something behind only when the
  // population count is two or more.
  assign low_cleared = vec_i & (vec_i - CAM_DEPTH'(1));
  assign found_o     = |vec_i;
  assign multi_o     = |low_cleared;

endmodule

// File: rtl/cam_search_pipe.sv
// Ternary CAM with flop storage and a two-stage search pipeline (S1 key regs, S2 result regs).
// Latency: 2 cycles from request acceptance to rsp_valid; one search per cycle sustained.
// Backpressure: S2 holds while rsp_valid && !rsp_ready; S1 holds behind it; req_ready drops only when both are full.
//
// Ports:
//   clk, rst (async, active-low)
//   wr_en/wr_inv/wr_addr/wr_data/wr_mask : write or invalidate one entry, always accepted
//   req_valid/req_ready/search_word/search_mask : search request handshake
//   rsp_valid/rsp_ready/match_vector/match_found/match_addr/multi_match : search result handshake
module cam_search_pipe
  import cam_pkg::*;
#(
  parameter int CAM_DEPTH = CAM_DEPTH_DEF,
  parameter int CAM_WIDTH = CAM_WIDTH_DEF,
  parameter int ADDR_W    = $clog2(CAM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 wr_inv,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [CAM_WIDTH-1:0] wr_data,
  input  logic [CAM_WIDTH-1:0] wr_mask,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [CAM_WIDTH-1:0] search_word,
  input  logic [CAM_WIDTH-1:0] search_mask,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CAM_DEPTH-1:0] match_vector,
  output logic                 match_found,
  output logic [ADDR_W-1:0]    match_addr,
  output logic                 multi_match
);

  // ---------------- storage ----------------
  logic [CAM_DEPTH-1:0] valid_q;
  logic [CAM_WIDTH-1:0] data_q  [CAM_DEPTH];
  logic [CAM_WIDTH-1:0] emask_q [CAM_DEPTH];
  logic                 wr_hit;

  // Only matters for non-power-of-two depths: out-of-range addresses are dropped.
  assign wr_hit = wr_en && ({1'b0, wr_addr} < (ADDR_W + 1)'(CAM_DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (wr_hit) begin
      valid_q[wr_addr] <= ~wr_inv;
    end
  end

  // Data and masks are deliberately left unreset; the valid bits gate them.
  always_ff @(posedge clk) begin
    if (wr_hit && !wr_inv) begin
      data_q[wr_addr]  <= wr_data;
      emask_q[wr_addr] <= wr_mask;
    end
  end

  // ---------------- pipeline state ----------------
  logic                 s1_valid_q, s1_valid_d;
  logic [CAM_WIDTH-1:0] s1_word_q, s1_word_d;
  logic [CAM_WIDTH-1:0] s1_mask_q, s1_mask_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [CAM_DEPTH-1:0] s2_vec_q, s2_vec_d;
  logic                 s2_found_q, s2_found_d;
  logic [ADDR_W-1:0]    s2_addr_q, s2_addr_d;
  logic                 s2_multi_q, s2_multi_d;

  logic                 s2_hold, s1_hold, req_acc;
  logic [CAM_DEPTH-1:0] cmp_vec;
  logic                 cmp_found, cmp_multi;
  logic [ADDR_W-1:0]    cmp_addr;

  assign s2_hold   = s2_valid_q && !rsp_ready;
  assign s1_hold   = s1_valid_q && s2_hold;
  assign req_ready = !s1_valid_q || !s2_hold;
  assign req_acc   = req_valid && req_ready;

  // Compare against the live array: a write landing on the edge that loaded
  // S1 is already visible when S2 loads on the following edge.
  always_comb begin
    cmp_vec = '0;
    for (int i = 0; i < CAM_DEPTH; i++) begin
      cmp_vec[i] = cam_entry_match(valid_q[i],
                                   CAM_MAX_W'(data_q[i]),
                                   CAM_MAX_W'(emask_q[i]),
                                   CAM_MAX_W'(s1_word_q),
                                   CAM_MAX_W'(s1_mask_q));
    end
  end

  cam_priority_enc #(
    .CAM_DEPTH (CAM_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_enc (
    .vec_i   (cmp_vec),
    .found_o (cmp_found),
    .addr_o  (cmp_addr),
    .multi_o (cmp_multi)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_word_d  = s1_word_q;
    s1_mask_d  = s1_mask_q;
    s2_valid_d = s2_valid_q;
    s2_vec_d   = s2_vec_q;
    s2_found_d = s2_found_q;
    s2_addr_d  = s2_addr_q;
    s2_multi_d = s2_multi_q;

    if (!s1_hold) begin
      s1_valid_d = req_acc;
      if (req_acc) begin
        s1_word_d = search_word;
        s1_mask_d = search_mask;
      end
    end

    // Result registers are zeroed when no search advances, so an idle output
    // reads as "no match".
    if (!s2_hold) begin
      s2_valid_d = s1_valid_q;
      s2_vec_d   = s1_valid_q ? cmp_vec   : '0;
      s2_found_d = s1_valid_q ? cmp_found : 1'b0;
      s2_addr_d  = s1_valid_q ? cmp_addr  : '0;
      s2_multi_d = s1_valid_q ? cmp_multi : 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_word_q  <= '0;
      s1_mask_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_vec_q   <= '0;
      s2_found_q <= 1'b0;
      s2_addr_q  <= '0;
      s2_multi_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_word_q  <= s1_word_d;
      s1_mask_q  <= s1_mask_d;
      s2_valid_q <= s2_valid_d;
      s2_vec_q   <= s2_vec_d;
      s2_found_q <= s2_found_d;
      s2_addr_q  <= s2_addr_d;
      s2_multi_q <= s2_multi_d;
    end
  end

  assign rsp_valid    = s2_valid_q;
  assign match_vector = s2_vec_q;
  assign match_found  = s2_found_q;
  assign match_addr   = s2_addr_q;
  assign multi_match  = s2_multi_q;

endmodule

// File: tb/tb_cam_search_pipe.sv
// Scoreboard bench for cam_search_pipe: stimulus pushes expected results, a monitor pops them.
// Latency: n/a.
// Backpressure: the bench drives rsp_ready low to exercise stalls.
module tb_cam_search_pipe;

  logic       clk;
  logic       rst;
  logic       wr_en, wr_inv;
  logic [2:0] wr_addr;
  logic [7:0] wr_data, wr_mask;
  logic       req_valid, req_ready;
  logic [7:0] search_word, search_mask;
  logic       rsp_valid, rsp_ready;
  logic [7:0] match_vector;
  logic       match_found;
  logic [2:0] match_addr;
  logic       multi_match;

  typedef struct packed {
    logic [7:0] vec;
    logic       found;
    logic [2:0] addr;
    logic       multi;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  cam_search_pipe dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_inv       (wr_inv),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_mask      (wr_mask),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .search_word  (search_word),
    .search_mask  (search_mask),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .match_vector (match_vector),
    .match_found  (match_found),
    .match_addr   (match_addr),
    .multi_match  (multi_match)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic prev_hold = 1'b0;
  exp_t held;

  always @(negedge clk) begin
    if (!rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 64'(rsp_valid), 64'(1));
        check("hold_vec",   64'(match_vector), 64'(held.vec));
        check("hold_addr",  64'(match_addr), 64'(held.addr));
        check("hold_found", 64'(match_found), 64'(held.found));
        check("hold_multi", 64'(multi_match), 64'(held.multi));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 64'(rsp_valid), 64'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("match_vector", 64'(match_vector), 64'(e.vec));
          check("match_found",  64'(match_found), 64'(e.found));
          check("match_addr",   64'(match_addr), 64'(e.addr));
          check("multi_match",  64'(multi_match), 64'(e.multi));
        end
      end
      prev_hold = rsp_valid && !rsp_ready;
      held = '{vec: match_vector, found: match_found, addr: match_addr, multi: multi_match};
    end
  end

  // ---------------- stimulus helpers (entered and left at posedge+1) ----------------
  task automatic do_write(input logic [2:0] a, input logic [7:0] d, input logic [7:0] m, input logic inv);
    wr_en = 1'b1; wr_inv = inv; wr_addr = a; wr_data = d; wr_mask = m;
    @(posedge clk); #1;
    wr_en = 1'b0; wr_inv = 1'b0;
  endtask

  task automatic do_search(input logic [7:0] w, input logic [7:0] m, input exp_t e, input bit expect_rsp);
    int n;
    req_valid = 1'b1; search_word = w; search_mask = m;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) check("req_ready_timeout", 64'(req_ready), 64'(1));
    if (expect_rsp) exp_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_done", 64'(exp_q.size()), 64'(0));
  endtask

  localparam exp_t NO_MATCH = '{vec: 8'h00, found: 1'b0, addr: 3'd0, multi: 1'b0};

  initial begin
    rst = 1'b0;
    wr_en = 1'b0; wr_inv = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
    req_valid = 1'b0; search_word = '0; search_mask = '0;
    rsp_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid",    64'(rsp_valid), 64'(0));
    check("rst_req_ready",    64'(req_ready), 64'(1));
    check("rst_match_vector", 64'(match_vector), 64'(0));
    check("rst_match_found",  64'(match_found), 64'(0));
    check("rst_match_addr",   64'(match_addr), 64'(0));
    check("rst_multi_match",  64'(multi_match), 64'(0));
    rst = 1'b1;

    // Single exact match.
    do_write(3'd3, 8'hA5, 8'h00, 1'b0);
    do_search(8'hA5, 8'h00, '{vec: 8'h08, found: 1'b1, addr: 3'd3, multi: 1'b0}, 1'b1);
    drain();

    // Masked entry plus exact entry both hit.
    do_write(3'd1, 8'hF0, 8'h0F, 1'b0);
    do_write(3'd5, 8'hF3, 8'h00, 1'b0);
    do_search(8'hF3, 8'h00, '{vec: 8'h22, found: 1'b1, addr: 3'd1, multi: 1'b1}, 1'b1);
    // Search mask ignores the upper nibble: entry 5 (low 3) and entry 1 (fully masked) hit.
    do_search(8'h03, 8'hF0, '{vec: 8'h22, found: 1'b1, addr: 3'd1, multi: 1'b1}, 1'b1);
    drain();

    // Invalidate entry 3.
    do_write(3'd3, 8'h00, 8'h00, 1'b1);
    do_search(8'hA5, 8'h00, NO_MATCH, 1'b1);
    drain();

    // Write and search accepted on the same edge.
    wr_en = 1'b1; wr_inv = 1'b0; wr_addr = 3'd0; wr_data = 8'h11; wr_mask = 8'h00;
    do_search(8'h11, 8'h00, '{vec: 8'h01, found: 1'b1, addr: 3'd0, multi: 1'b0}, 1'b1);
    wr_en = 1'b0;
    drain();

    // Backpressure: two searches fill the pipe, the third waits.
    rsp_ready = 1'b0;
    do_search(8'h11, 8'h00, '{vec: 8'h01, found: 1'b1, addr: 3'd0, multi: 1'b0}, 1'b1);
    do_search(8'hF3, 8'h00, '{vec: 8'h22, found: 1'b1, addr: 3'd1, multi: 1'b1}, 1'b1);
    check("bp_req_ready_low", 64'(req_ready), 64'(0));
    check("bp_rsp_valid",     64'(rsp_valid), 64'(1));
    // Array change while the result sits in S2; the held outputs must not move.
    do_write(3'd6, 8'h11, 8'h00, 1'b0);
    for (int i = 0; i < 2; i++) begin
      check("bp_req_ready_stays_low", 64'(req_ready), 64'(0));
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    #1;
    // Fully masked search hits every valid entry: 0,1,5,6.
    do_search(8'h00, 8'hFF, '{vec: 8'h63, found: 1'b1, addr: 3'd0, multi: 1'b1}, 1'b1);
    drain();

    // Reset with two searches in flight.
    req_valid = 1'b1; search_word = 8'h11; search_mask = 8'h00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("pre_rst_rsp_valid", 64'(rsp_valid), 64'(1));
    rst = 1'b0;
    #1;
    check("midrst_rsp_valid",   64'(rsp_valid), 64'(0));
    check("midrst_req_ready",   64'(req_ready), 64'(1));
    check("midrst_match_found", 64'(match_found), 64'(0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    check("post_rst_req_ready", 64'(req_ready), 64'(1));
    // All entries invalid now, even with every bit masked.
    do_search(8'h11, 8'h00, NO_MATCH, 1'b1);
    do_search(8'h00, 8'hFF, NO_MATCH, 1'b1);
    drain();
    repeat (5) @(posedge clk);
    #1;
    check("final_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
